bp_me_io_cfg_responder: RTL and testbench

- BedRock IO-command responder that terminates uncached load/store traffic from an NBF-style loader or host initiator.
- Provides a small bank of 64-bit scratch/config registers plus a "done" register.
- Answers every command with a BedRock response on the paired response channel.
- Sits on the loader side of the tethered ethernet CPU bench and in standalone ME unit benches as the responding endpoint.

---
 rtl/bp_me_io_cfg_responder.sv | 163 ++++++++++++++++
 tb/tb_bp_me_io_cfg_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_io_cfg_responder.sv
// BedRock IO-command responder: a small bank of 64-bit scratch/config registers
// plus a sticky done flag, answering every command with one held response.
module bp_me_io_cfg_responder #(
    parameter int paddr_width_p = 40,
    parameter int data_width_p = 64,
    parameter int els_p = 8,
    parameter logic [paddr_width_p-1:0] base_addr_p = 40'h0010_0000,
    parameter int done_idx_p = els_p - 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [3:0]               io_cmd_msg_type_i,
    input  logic [paddr_width_p-1:0] io_cmd_addr_i,
    input  logic [2:0]               io_cmd_size_i,
    input  logic [7:0]               io_cmd_payload_i,
    input  logic [data_width_p-1:0]  io_cmd_data_i,
    input  logic                     io_cmd_v_i,
    output logic                     io_cmd_yumi_o,
    output logic [3:0]               io_resp_msg_type_o,
    output logic [paddr_width_p-1:0] io_resp_addr_o,
    output logic [2:0]               io_resp_size_o,
    output logic [7:0]               io_resp_payload_o,
    output logic [data_width_p-1:0]  io_resp_data_o,
    output logic                     io_resp_err_o,
    output logic                     io_resp_v_o,
    input  logic                     io_resp_ready_and_i,
    output logic                     done_o,
    output logic [15:0]              err_count_o
);

    localparam int lg_els_lp = $clog2(els_p);
    localparam logic [paddr_width_p-1:0] span_lp = paddr_width_p'(els_p * 8);
    localparam logic [lg_els_lp-1:0] done_idx_lp = lg_els_lp'(done_idx_p);

    typedef enum logic {eReady, eResp} state_e;

    state_e state_r, state_n;

    logic [data_width_p-1:0] regs_r [els_p];

    logic [paddr_width_p-1:0] offset;
    logic [lg_els_lp-1:0]     idx;
    logic [2:0]               lane;
    logic [5:0]               lane_bits;
    logic                     in_range;
    logic                     misaligned;
    logic                     cmd_err;
    logic                     is_write;
    logic                     wr_fire;
    logic [7:0]               size_mask;
    logic [7:0]               lane_mask;
    logic [data_width_p-1:0]  cur;
    logic [data_width_p-1:0]  wdata_sh;
    logic [data_width_p-1:0]  merged;
    logic [data_width_p-1:0]  data_mask;
    logic [data_width_p-1:0]  rd_sh;
    logic [data_width_p-1:0]  rd_data;

    // Address decode, error classification and the byte-lane datapath, all
    // evaluated against the command currently presented on the input channel.
    always_comb begin
        offset     = io_cmd_addr_i - base_addr_p;
        in_range   = (io_cmd_addr_i >= base_addr_p) && (offset < span_lp);
        idx        = offset[3 +: lg_els_lp];
        lane       = offset[2:0];
        lane_bits  = {lane, 3'b000};
        size_mask  = 8'h00;
        misaligned = 1'b0;
        case (io_cmd_size_i)
            3'd0: size_mask = 8'h01;
            3'd1: begin size_mask = 8'h03; misaligned = offset[0];      end
            3'd2: begin size_mask = 8'h0F; misaligned = |offset[1:0];  end
            3'd3: begin size_mask = 8'hFF; misaligned = |offset[2:0];  end
            default: begin size_mask = 8'h00; misaligned = 1'b0;      end
        endcase
        cmd_err   = (io_cmd_msg_type_i > 4'd3) || (io_cmd_size_i > 3'd3)
                    || !in_range || misaligned;
        is_write  = io_cmd_msg_type_i[0];
        lane_mask = size_mask << lane;
        cur       = regs_r[idx];
        wdata_sh  = io_cmd_data_i << lane_bits;
        merged    = cur;
        data_mask = '0;
        for (int b = 0; b < 8; b++) begin
            merged[b*8 +: 8]    = lane_mask[b] ? wdata_sh[b*8 +: 8] : cur[b*8 +: 8];
            data_mask[b*8 +: 8] = {8{size_mask[b]}};
        end
        // Narrow reads are replicated so any lane of the response holds the value.
        rd_sh = cur >> lane_bits;
        case (io_cmd_size_i)
            3'd0:    rd_data = {8{rd_sh[7:0]}};
            3'd1:    rd_data = {4{rd_sh[15:0]}};
            3'd2:    rd_data = {2{rd_sh[31:0]}};
            default: rd_data = rd_sh;
        endcase
    end

    // Accept a command only when no response is outstanding.
    always_comb begin
        state_n       = state_r;
        io_cmd_yumi_o = 1'b0;
        io_resp_v_o   = 1'b0;
        case (state_r)
            eReady: begin
                io_cmd_yumi_o = io_cmd_v_i;
                if (io_cmd_v_i) state_n = eResp;
            end
            eResp: begin
                io_resp_v_o = 1'b1;
                if (io_resp_ready_and_i) state_n = eReady;
            end
            default: state_n = eReady;
        endcase
    end

    assign wr_fire = io_cmd_yumi_o && !cmd_err && is_write;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= eReady;
        else         state_r <= state_n;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) regs_r[i] <= '0;
        end else if (wr_fire) begin
            regs_r[idx] <= merged;
        end
    end

    // The response is captured on the accept cycle and then held untouched
    // until the consumer takes it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            io_resp_msg_type_o <= '0;
            io_resp_addr_o     <= '0;
            io_resp_size_o     <= '0;
            io_resp_payload_o  <= '0;
            io_resp_data_o     <= '0;
            io_resp_err_o      <= 1'b0;
        end else if (io_cmd_yumi_o) begin
            io_resp_msg_type_o <= io_cmd_msg_type_i;
            io_resp_addr_o     <= io_cmd_addr_i;
            io_resp_size_o     <= io_cmd_size_i;
            io_resp_payload_o  <= io_cmd_payload_i;
            io_resp_data_o     <= (cmd_err || is_write) ? '0 : rd_data;
            io_resp_err_o      <= cmd_err;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_count_o <= '0;
            done_o      <= 1'b0;
        end else begin
            if (io_cmd_yumi_o && cmd_err && (err_count_o != 16'hFFFF))
                err_count_o <= err_count_o + 16'd1;
            if (wr_fire && (idx == done_idx_lp) && |(io_cmd_data_i & data_mask))
                done_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_me_io_cfg_responder.sv
// Self-checking bench for bp_me_io_cfg_responder: directed scenarios followed by
// randomized commands compared against a byte-level register-file model.
module tb_bp_me_io_cfg_responder;

    localparam int PW = 40;
    localparam int ELS = 8;
    localparam logic [39:0] BASE = 40'h0010_0000;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [3:0]    io_cmd_msg_type_i;
    logic [PW-1:0] io_cmd_addr_i;
    logic [2:0]    io_cmd_size_i;
    logic [7:0]    io_cmd_payload_i;
    logic [63:0]   io_cmd_data_i;
    logic          io_cmd_v_i;
    logic          io_cmd_yumi_o;
    logic [3:0]    io_resp_msg_type_o;
    logic [PW-1:0] io_resp_addr_o;
    logic [2:0]    io_resp_size_o;
    logic [7:0]    io_resp_payload_o;
    logic [63:0]   io_resp_data_o;
    logic          io_resp_err_o;
    logic          io_resp_v_o;
    logic          io_resp_ready_and_i;
    logic          done_o;
    logic [15:0]   err_count_o;

    bp_me_io_cfg_responder #(
        .paddr_width_p(PW),
        .data_width_p(64),
        .els_p(ELS),
        .base_addr_p(BASE),
        .done_idx_p(ELS - 1)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .io_cmd_msg_type_i(io_cmd_msg_type_i),
        .io_cmd_addr_i(io_cmd_addr_i),
        .io_cmd_size_i(io_cmd_size_i),
        .io_cmd_payload_i(io_cmd_payload_i),
        .io_cmd_data_i(io_cmd_data_i),
        .io_cmd_v_i(io_cmd_v_i),
        .io_cmd_yumi_o(io_cmd_yumi_o),
        .io_resp_msg_type_o(io_resp_msg_type_o),
        .io_resp_addr_o(io_resp_addr_o),
        .io_resp_size_o(io_resp_size_o),
        .io_resp_payload_o(io_resp_payload_o),
        .io_resp_data_o(io_resp_data_o),
        .io_resp_err_o(io_resp_err_o),
        .io_resp_v_o(io_resp_v_o),
        .io_resp_ready_and_i(io_resp_ready_and_i),
        .done_o(done_o),
        .err_count_o(err_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int fails = 0;

    logic [63:0] model_regs [ELS];
    logic        model_done;
    int          model_errs;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < ELS; i++) model_regs[i] = '0;
        model_done = 1'b0;
        model_errs = 0;
    endtask

    // Reference behaviour expressed directly in bytes: offsets, lane counts and
    // a replicated read built by indexing the read bytes modulo the access size.
    task automatic modelCmd(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                            input logic [63:0] d, output logic [63:0] rdata, output logic err);
        longint off;
        int n, idx, lane;
        logic [63:0] v, m;
        rdata = '0;
        n = (s <= 3'd3) ? (1 << s) : 0;
        off = longint'({24'b0, a}) - longint'({24'b0, BASE});
        err = (t > 4'd3) || (n == 0) || (off < 0) || (off >= longint'(ELS * 8));
        if (!err && ((off % n) != 0)) err = 1'b1;
        if (err) begin
            if (model_errs < 65535) model_errs++;
            return;
        end
        idx = int'(off / 8);
        lane = int'(off % 8);
        if (t[0]) begin
            m = '0;
            for (int i = 0; i < n; i++) begin
                model_regs[idx][(lane + i) * 8 +: 8] = d[i * 8 +: 8];
                m[i * 8 +: 8] = 8'hFF;
            end
            if (idx == ELS - 1 && (d & m) != 64'd0) model_done = 1'b1;
        end else begin
            v = model_regs[idx] >> (lane * 8);
            for (int b = 0; b < 8; b++) rdata[b * 8 +: 8] = v[(b % n) * 8 +: 8];
        end
    endtask

    task automatic checkResp(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                             input logic [7:0] pl, input logic [63:0] ed, input logic ee);
        checkOutput("resp_v", 64'(io_resp_v_o), 64'd1);
        checkOutput("resp_type", 64'(io_resp_msg_type_o), 64'(t));
        checkOutput("resp_addr", 64'(io_resp_addr_o), 64'(a));
        checkOutput("resp_size", 64'(io_resp_size_o), 64'(s));
        checkOutput("resp_payload", 64'(io_resp_payload_o), 64'(pl));
        checkOutput("resp_data", io_resp_data_o, ed);
        checkOutput("resp_err", 64'(io_resp_err_o), 64'(ee));
    endtask

    // One full command: present it, expect acceptance, expect the response one
    // cycle later, hold it for 'hold' cycles with another command pending, then accept it.
    task automatic applyStimulus(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                                 input logic [7:0] pl, input logic [63:0] d, input int hold);
        logic [63:0] ed;
        logic ee;
        int n;
        @(negedge clk_i);
        io_cmd_msg_type_i = t;
        io_cmd_addr_i = a;
        io_cmd_size_i = s;
        io_cmd_payload_i = pl;
        io_cmd_data_i = d;
        io_cmd_v_i = 1'b1;
        io_resp_ready_and_i = 1'b0;
        #1;
        n = 0;
        while (!io_cmd_yumi_o && n < 20) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        checkOutput("yumi", 64'(io_cmd_yumi_o), 64'd1);
        modelCmd(t, a, s, d, ed, ee);
        @(posedge clk_i);
        #1;
        io_cmd_v_i = 1'b0;
        checkResp(t, a, s, pl, ed, ee);
        checkOutput("done", 64'(done_o), 64'(model_done));
        checkOutput("err_count", 64'(err_count_o), 64'(model_errs));
        for (int h = 0; h < hold; h++) begin
            io_cmd_v_i = 1'b1;
            @(negedge clk_i);
            checkOutput("yumi_held", 64'(io_cmd_yumi_o), 64'd0);
            checkResp(t, a, s, pl, ed, ee);
            @(posedge clk_i);
            #1;
        end
        io_cmd_v_i = 1'b0;
        io_resp_ready_and_i = 1'b1;
        @(posedge clk_i);
        #1;
        io_resp_ready_and_i = 1'b0;
        checkOutput("resp_v_drop", 64'(io_resp_v_o), 64'd0);
    endtask

    task automatic doReset();
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        modelReset();
        checkOutput("rst_resp_v", 64'(io_resp_v_o), 64'd0);
        checkOutput("rst_done", 64'(done_o), 64'd0);
        checkOutput("rst_err_count", 64'(err_count_o), 64'd0);
        checkOutput("rst_resp_data", io_resp_data_o, 64'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        logic [3:0] t;
        logic [2:0] s;
        logic [39:0] a;
        int idx, lane, r;

        reset_i = 1'b1;
        io_cmd_msg_type_i = '0;
        io_cmd_addr_i = '0;
        io_cmd_size_i = '0;
        io_cmd_payload_i = '0;
        io_cmd_data_i = '0;
        io_cmd_v_i = 1'b0;
        io_resp_ready_and_i = 1'b0;
        modelReset();
        repeat (2) @(negedge clk_i);
        checkOutput("init_yumi", 64'(io_cmd_yumi_o), 64'd0);
        checkOutput("init_resp_v", 64'(io_resp_v_o), 64'd0);
        checkOutput("init_resp_err", 64'(io_resp_err_o), 64'd0);
        checkOutput("init_done", 64'(done_o), 64'd0);
        checkOutput("init_err_count", 64'(err_count_o), 64'd0);
        reset_i = 1'b0;

        applyStimulus(4'd1, 40'h10_0008, 3'd3, 8'h11, 64'h1122_3344_5566_7788, 0);
        applyStimulus(4'd2, 40'h10_0008, 3'd3, 8'h12, 64'h0, 0);
        applyStimulus(4'd3, 40'h10_000B, 3'd0, 8'h13, 64'hEE, 0);
        applyStimulus(4'd2, 40'h10_0008, 3'd3, 8'h14, 64'h0, 0);
        applyStimulus(4'd0, 40'h10_000B, 3'd0, 8'h15, 64'h0, 5);
        checkOutput("dir_reg1", model_regs[1], 64'h1122_3344_EE66_7788);

        applyStimulus(4'd2, 40'h0F_FFF8, 3'd3, 8'h21, 64'h0, 0);
        applyStimulus(4'd0, 40'h10_0000, 3'd4, 8'h22, 64'h0, 1);
        applyStimulus(4'd5, 40'h10_0000, 3'd3, 8'h23, 64'hFFFF, 0);
        applyStimulus(4'd3, 40'h10_0002, 3'd2, 8'h24, 64'hFFFF_FFFF, 0);
        checkOutput("dir_err_count", 64'(err_count_o), 64'd4);
        applyStimulus(4'd0, 40'h10_0008, 3'd3, 8'h25, 64'h0, 0);
        applyStimulus(4'd0, 40'h10_0000, 3'd3, 8'h26, 64'h0, 0);

        applyStimulus(4'd1, 40'h10_0038, 3'd3, 8'h31, 64'h1, 2);
        repeat (3) @(negedge clk_i);
        checkOutput("done_sticky", 64'(done_o), 64'd1);
        applyStimulus(4'd0, 40'h10_0038, 3'd3, 8'h32, 64'h0, 0);
        doReset();

        // Reset while a response is outstanding must drop it for good.
        applyStimulus(4'd1, 40'h10_0000, 3'd3, 8'h41, 64'hCAFE_F00D_1234_5678, 0);
        @(negedge clk_i);
        io_cmd_msg_type_i = 4'd0;
        io_cmd_addr_i = 40'h10_0000;
        io_cmd_size_i = 3'd3;
        io_cmd_payload_i = 8'h42;
        io_cmd_v_i = 1'b1;
        @(posedge clk_i);
        #1;
        io_cmd_v_i = 1'b0;
        checkOutput("pre_reset_resp_v", 64'(io_resp_v_o), 64'd1);
        reset_i = 1'b1;
        #1;
        checkOutput("mid_reset_resp_v", 64'(io_resp_v_o), 64'd0);
        modelReset();
        @(negedge clk_i);
        reset_i = 1'b0;
        io_resp_ready_and_i = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            checkOutput("no_stale_resp", 64'(io_resp_v_o), 64'd0);
        end
        io_resp_ready_and_i = 1'b0;
        applyStimulus(4'd0, 40'h10_0000, 3'd3, 8'h43, 64'h0, 0);

        for (int k = 0; k < 120; k++) begin
            r = $urandom_range(0, 11);
            t = (r < 10) ? 4'(r % 4) : 4'($urandom_range(4, 15));
            s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            idx = $urandom_range(0, ELS - 1);
            lane = $urandom_range(0, 7);
            if (s <= 3'd3 && $urandom_range(0, 7) != 0) lane = (lane >> s) << s;
            a = BASE + 40'(idx * 8 + lane);
            r = $urandom_range(0, 15);
            if (r == 0) a = BASE - 40'($urandom_range(1, 16));
            if (r == 1) a = BASE + 40'(ELS * 8 + $urandom_range(0, 15));
            applyStimulus(t, a, s, 8'($urandom), {$urandom, $urandom}, $urandom_range(0, 3));
        end

        for (int i = 0; i < ELS; i++)
            applyStimulus(4'd2, BASE + 40'(i * 8), 3'd3, 8'(i), 64'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
